// File: rtl/risc16ba_io.sv
// risc16ba_io: memory-mapped LED registers and prescaled down-counting timer on the risc16ba data port.
// Optional: define RISC16_TIMER_IRQ_EN to store CTRL.IE and drive a registered timer interrupt.
module risc16ba_io #(
    parameter logic [15:0] BASE     = 16'h0200,
    parameter int unsigned PRESCALE = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] daddr,
    input  logic [15:0] ddout,
    input  logic        doe,
    input  logic        dwe0,
    input  logic        dwe1,
    output logic [15:0] rdata,
    output logic        hit,
    output logic [23:0] led,
    output logic        irq
);
    localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

    typedef enum logic { IDLE, RUN } tmr_state_t;
    typedef enum logic [2:0] {
        REG_LED_A  = 3'd0,
        REG_LED_B  = 3'd1,
        REG_CNT    = 3'd2,
        REG_RELOAD = 3'd3,
        REG_CTRL   = 3'd4
    } reg_sel_t;

    tmr_state_t  state_q, state_d;
    logic [7:0]  led_0, led_1, led_2;
    logic [15:0] reload_q;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pre_q, pre_d;
    logic        auto_q;
    logic        ie_q;
    logic        exp_q, exp_d;
    logic        exp_set;
    logic        tick;
    logic [2:0]  sel;
    logic        wr_even, wr_odd;
    logic        ctrl_wr_lo, exp_clr;
    logic [15:0] rsel;
    logic        unused_addr;

    assign unused_addr = daddr[0];
    assign hit     = (daddr & 16'hfff0) == BASE;
    assign sel     = daddr[3:1];
    assign wr_even = hit & dwe0;
    assign wr_odd  = hit & dwe1;
    assign ctrl_wr_lo = wr_odd && (sel == REG_CTRL);
    assign exp_clr    = wr_even && (sel == REG_CTRL) && ddout[8];
    assign led = {led_2, led_1, led_0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_0    <= '0;
            led_1    <= '0;
            led_2    <= '0;
            reload_q <= '0;
            auto_q   <= 1'b0;
        end else begin
            if (wr_odd  && sel == REG_LED_A)  led_0 <= ddout[7:0];
            if (wr_even && sel == REG_LED_A)  led_1 <= ddout[15:8];
            if (wr_odd  && sel == REG_LED_B)  led_2 <= ddout[7:0];
            if (wr_even && sel == REG_RELOAD) reload_q[15:8] <= ddout[15:8];
            if (wr_odd  && sel == REG_RELOAD) reload_q[7:0]  <= ddout[7:0];
            if (ctrl_wr_lo)                   auto_q <= ddout[1];
        end
    end

`ifdef RISC16_TIMER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_wr_lo) ie_q <= ddout[2];
            irq_q <= exp_q & ie_q;
        end
    end

    assign irq = irq_q;
`else
    assign ie_q = 1'b0;
    assign irq  = 1'b0;
`endif

    assign tick = (state_q == RUN) && (pre_q == PRE_MAX);

    // An EN-changing CTRL write takes priority over a same-edge tick, so no expiry that cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pre_d   = pre_q;
        exp_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_wr_lo && ddout[0]) begin
                    state_d = RUN;
                    cnt_d   = reload_q;
                    pre_d   = '0;
                end
            end
            RUN: begin
                if (ctrl_wr_lo && !ddout[0]) begin
                    state_d = IDLE;
                end else begin
                    pre_d = tick ? '0 : pre_q + 16'd1;
                    if (tick) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 16'd1;
                        end else begin
                            exp_set = 1'b1;
                            if (auto_q) cnt_d = reload_q;
                            else        state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        exp_d = exp_set | (exp_q & ~exp_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pre_q   <= '0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            exp_q   <= exp_d;
        end
    end

    always_comb begin
        rsel = '0;
        case (sel)
            REG_LED_A:  rsel = {led_1, led_0};
            REG_LED_B:  rsel = {8'h00, led_2};
            REG_CNT:    rsel = cnt_q;
            REG_RELOAD: rsel = reload_q;
            REG_CTRL:   rsel = {7'b0, exp_q, 5'b0, ie_q, auto_q, state_q == RUN};
            default:    rsel = '0;
        endcase
        rdata = (doe && hit) ? rsel : '0;
    end

endmodule

// File: tb/tb_risc16ba_io.sv
// Self-checking bench for risc16ba_io: LED/register vector table, timer corner sequences,
// randomized bus traffic against a behavioural model, and asynchronous reset mid-count.
module tb_risc16ba_io;
    localparam logic [15:0] BASE     = 16'h0200;
    localparam int unsigned PRESCALE = 4;

    logic        clk;
    logic        rst;
    logic [15:0] daddr;
    logic [15:0] ddout;
    logic        doe;
    logic        dwe0;
    logic        dwe1;
    logic [15:0] rdata;
    logic        hit;
    logic [23:0] led;
    logic        irq;

    risc16ba_io #(.BASE(BASE), .PRESCALE(PRESCALE)) dut (
        .clk  (clk),
        .rst  (rst),
        .daddr(daddr),
        .ddout(ddout),
        .doe  (doe),
        .dwe0 (dwe0),
        .dwe1 (dwe1),
        .rdata(rdata),
        .hit  (hit),
        .led  (led),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // behavioural model state
    logic [23:0] m_led;
    logic [15:0] m_reload, m_cnt;
    int unsigned m_pre;
    logic        m_en, m_auto, m_ie, m_exp, m_irq;

    // values sampled just before the active edge by apply()
    logic [15:0] s_rd;
    logic        s_hit, s_irq;
    logic [23:0] s_led;

`ifdef RISC16_TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        m_led = '0; m_reload = '0; m_cnt = '0; m_pre = 0;
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_irq = 0;
    endtask

    function automatic logic [15:0] mread(input logic [15:0] a, input logic oe);
        logic [15:0] v;
        if (!oe || ((a & 16'hfff0) != BASE)) return 16'h0000;
        case (a[3:1])
            3'd0:    v = m_led[15:0];
            3'd1:    v = {8'h00, m_led[23:16]};
            3'd2:    v = m_cnt;
            3'd3:    v = m_reload;
            3'd4:    v = {7'b0, m_exp, 5'b0, m_ie, m_auto, m_en};
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    // One clock edge of the register map and timer rules, using pre-edge state throughout.
    task automatic mstep(input logic [15:0] a, input logic [15:0] d, input logic w0, input logic w1);
        logic        h, cw, tk, expire, nen, nexp, nirq;
        logic [2:0]  off;
        logic [15:0] rl_old, ncnt;
        int unsigned npre;
        h      = (a & 16'hfff0) == BASE;
        off    = a[3:1];
        cw     = h && off == 3'd4 && w1;
        rl_old = m_reload;
        nirq   = m_exp & m_ie;
        if (h && off == 3'd0 && w1) m_led[7:0]   = d[7:0];
        if (h && off == 3'd0 && w0) m_led[15:8]  = d[15:8];
        if (h && off == 3'd1 && w1) m_led[23:16] = d[7:0];
        if (h && off == 3'd3 && w0) m_reload[15:8] = d[15:8];
        if (h && off == 3'd3 && w1) m_reload[7:0]  = d[7:0];
        expire = 0; nen = m_en; ncnt = m_cnt; npre = m_pre;
        if (cw && d[0] != m_en) begin
            nen = d[0];
            if (d[0]) begin ncnt = rl_old; npre = 0; end
        end else if (m_en) begin
            tk   = (m_pre == PRESCALE - 1);
            npre = tk ? 0 : m_pre + 1;
            if (tk) begin
                if (m_cnt != 0) ncnt = m_cnt - 16'd1;
                else begin
                    expire = 1;
                    if (m_auto) ncnt = rl_old;
                    else        nen = 0;
                end
            end
        end
        nexp = m_exp;
        if (h && off == 3'd4 && w0 && d[8]) nexp = 0;
        if (expire) nexp = 1;
        if (cw) m_auto = d[1];
        if (cw && IRQ_ON) m_ie = d[2];
        m_en = nen; m_cnt = ncnt; m_pre = npre; m_exp = nexp;
        m_irq = IRQ_ON ? nirq : 1'b0;
    endtask

    // Drive one bus cycle (entered at posedge+1), check against the model, clock it.
    task automatic apply(input logic [15:0] a, input logic [15:0] d, input logic oe,
                         input logic w0, input logic w1);
        daddr = a; ddout = d; doe = oe; dwe0 = w0; dwe1 = w1;
        #2;
        s_rd = rdata; s_hit = hit; s_led = led; s_irq = irq;
        chk("model_rdata", 32'(s_rd), 32'(mread(a, oe)));
        chk("model_hit", 32'(s_hit), 32'((a & 16'hfff0) == BASE));
        chk("model_led", 32'(s_led), 32'(m_led));
        chk("model_irq", 32'(s_irq), 32'(m_irq));
        @(posedge clk);
        mstep(a, d, w0, w1);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic        oe, w0, w1;
        logic [15:0] rd;
        logic        h;
        logic [23:0] led_after;
    } vec_t;

    vec_t tv[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, d, base_ctrl;
        logic [1:0]  w;
        int          r;

        tv[0]  = '{16'h0204, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 24'h000000};
        tv[1]  = '{16'h0206, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 24'h000000};
        tv[2]  = '{16'h0208, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 24'h000000};
        tv[3]  = '{16'h0200, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 24'h000000};
        tv[4]  = '{16'h0200, 16'hABCD, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 24'h00ABCD};
        tv[5]  = '{16'h0202, 16'h0012, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 24'h12ABCD};
        tv[6]  = '{16'h0202, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0012, 1'b1, 24'h12ABCD};
        tv[7]  = '{16'h0200, 16'h1100, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 24'h1211CD};
        tv[8]  = '{16'h0201, 16'h1100, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 24'h1211CD};
        tv[9]  = '{16'h0201, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h11CD, 1'b1, 24'h1211CD};
        tv[10] = '{16'h0210, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 24'h1211CD};
        tv[11] = '{16'h0202, 16'hFF00, 1'b1, 1'b1, 1'b0, 16'h0012, 1'b1, 24'h1211CD};
        tv[12] = '{16'h020A, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 24'h1211CD};
        tv[13] = '{16'h0204, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 24'h1211CD};
        tv[14] = '{16'h0204, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 24'h1211CD};
        tv[15] = '{16'h0200, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h11CD, 1'b1, 24'h1211CD};
        tv[16] = '{16'h020F, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 24'h1211CD};
        tv[17] = '{16'h1200, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 24'h1211CD};

        rst = 1'b1; daddr = 16'h0200; ddout = '0; doe = 0; dwe0 = 0; dwe1 = 0;
        mreset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_led", 32'(led), 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        chk("reset_rdata_doe0", 32'(rdata), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            apply(tv[i].a, tv[i].d, tv[i].oe, tv[i].w0, tv[i].w1);
            chk($sformatf("tbl%0d_rdata", i), 32'(s_rd), 32'(tv[i].rd));
            chk($sformatf("tbl%0d_hit", i), 32'(s_hit), 32'(tv[i].h));
            chk($sformatf("tbl%0d_led", i), 32'(led), 32'(tv[i].led_after));
        end

        // One-shot: RELOAD=3, EN=1; CNT steps every PRESCALE cycles, expiry 16 edges after EN write.
        apply(16'h0206, 16'h0003, 0, 1, 1);
        apply(16'h0208, 16'h0001, 0, 0, 1);
        for (int k = 1; k <= 16; k++) begin
            apply(16'h0204, 16'h0000, 1, 0, 0);
            chk($sformatf("oneshot_cnt_k%0d", k), 32'(s_rd), 32'(3 - (k - 1) / 4));
        end
        apply(16'h0208, 16'h0000, 1, 0, 0);
        chk("oneshot_ctrl_expired", 32'(s_rd), 32'h0100);

        // AUTO: RELOAD=2, expiry every 3 ticks; W1C clear, then a clear landing on the expiry edge.
        apply(16'h0208, 16'h0100, 0, 1, 1);
        apply(16'h0206, 16'h0002, 0, 1, 1);
        apply(16'h0208, 16'h0003, 0, 0, 1);
        for (int k = 1; k <= 12; k++) begin
            apply(16'h0208, 16'h0000, 1, 0, 0);
            chk($sformatf("auto_ctrl_k%0d", k), 32'(s_rd), 32'h0003);
        end
        apply(16'h0208, 16'h0000, 1, 0, 0);
        chk("auto_ctrl_exp", 32'(s_rd), 32'h0103);
        apply(16'h0208, 16'h0100, 0, 1, 0);
        apply(16'h0208, 16'h0000, 1, 0, 0);
        chk("auto_ctrl_cleared", 32'(s_rd), 32'h0003);
        for (int k = 16; k <= 23; k++) begin
            apply(16'h0208, 16'h0000, 1, 0, 0);
            chk($sformatf("auto2_ctrl_k%0d", k), 32'(s_rd), 32'h0003);
        end
        apply(16'h0208, 16'h0100, 1, 1, 0);
        chk("auto_clear_on_expiry_pre", 32'(s_rd), 32'h0003);
        apply(16'h0208, 16'h0000, 1, 0, 0);
        chk("auto_set_beats_clear", 32'(s_rd), 32'h0103);

        // IRQ: RELOAD=0 with AUTO+IE; EXP on every tick, irq one cycle after EXP.
        base_ctrl = IRQ_ON ? 16'h0007 : 16'h0003;
        apply(16'h0208, 16'h0100, 0, 1, 1);
        apply(16'h0206, 16'h0000, 0, 1, 1);
        apply(16'h0208, 16'h0007, 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            apply(16'h0208, 16'h0000, 1, 0, 0);
            chk($sformatf("irq_ctrl_k%0d", k), 32'(s_rd), 32'(k <= 4 ? base_ctrl : base_ctrl | 16'h0100));
            chk($sformatf("irq_k%0d", k), 32'(s_irq), 32'(k == 6 ? IRQ_ON : 1'b0));
        end
        apply(16'h0208, 16'h0100, 1, 1, 0);
        apply(16'h0208, 16'h0000, 1, 0, 0);
        chk("reload0_cleared", 32'(s_rd), 32'(base_ctrl));
        apply(16'h0208, 16'h0000, 1, 0, 0);
        chk("reload0_exp_next_tick", 32'(s_rd), 32'(base_ctrl | 16'h0100));

        // Randomized bus traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 8)       a = 16'h0210 + 16'($urandom_range(0, 15));
            else if (r < 12) a = 16'($urandom);
            else             a = BASE | 16'($urandom_range(0, 15));
            d = 16'($urandom);
            if (a[3:1] == 3'd3 && $urandom_range(0, 1) == 1) d = 16'($urandom_range(0, 6));
            w = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 6) w = 2'b00;
            apply(a, d, 1'($urandom_range(0, 1)), w[1], w[0]);
        end

        // Asynchronous reset while the timer is counting.
        apply(16'h0200, 16'hFFFF, 0, 1, 1);
        apply(16'h0208, 16'h0000, 0, 0, 1);
        apply(16'h0206, 16'h0032, 0, 1, 1);
        apply(16'h0208, 16'h0001, 0, 0, 1);
        for (int k = 0; k < 6; k++) apply(16'h0204, 16'h0000, 1, 0, 0);
        chk("prereset_cnt", 32'(s_rd), 32'h0031);
        daddr = 16'h0204; doe = 1; dwe0 = 0; dwe1 = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(led), 32'h0);
        chk("async_rst_cnt", 32'(rdata), 32'h0);
        chk("async_rst_irq", 32'(irq), 32'h0);
        mreset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply(16'h0208, 16'h0000, 1, 0, 0);
        chk("post_rst_ctrl", 32'(s_rd), 32'h0);
        apply(16'h0204, 16'h0000, 1, 0, 0);
        chk("post_rst_cnt_frozen", 32'(s_rd), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
